// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The uart_tx_state_e encoding covers the optional PARITY state used when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam int UART_DATA_BITS = 8;

    // Integer division: any remainder is dropped, so the real baud rate may be slightly fast.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a registered free-entry count.
// The pointers carry one extra MSB so that full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   free
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [PW-1:0] FREE_RESET = PW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    free_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign dout = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
    assign free = free_reg;

    // Storage has no reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            free_reg   <= FREE_RESET;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   free_reg <= free_reg - PTR_ONE;
                2'b01:   free_reg <= free_reg + PTR_ONE;
                default: free_reg <= free_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser with baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [7:0]                i_data_in,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    output logic [TX_FIFO_DEPTH:0]    o_tx_free,
    output logic                      o_tx,
    output logic                      o_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e             state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [2:0]                 bit_reg, bit_next;
    logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
    logic                       tx_reg, tx_next;
    logic                       busy_reg, busy_next;
`ifdef UART_TX_PARITY_EN
    logic                       parity_reg, parity_next;
`endif

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [7:0]                 fifo_dout;
    logic                       baud_done;

    assign fifo_push  = i_wr_valid && !fifo_full;
    assign o_wr_ready = !fifo_full;
    assign o_tx       = tx_reg;
    assign o_busy     = busy_reg;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (TX_FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (i_data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (o_tx_free)
    );

    assign baud_done = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    cnt_next   = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Line level is registered, so it is decoded from where the FSM is heading.
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a frame-timeline reference model.
// Honours UART_TX_PARITY_EN to expect 11-bit frames.
module tb_uart_tx_fifo;

    localparam int CLK_HZ     = 400;
    localparam int BAUD       = 100;
    localparam int DEPTH_LOG2 = 2;
    localparam int C          = CLK_HZ / BAUD;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif
    localparam int F = FRAME_BITS * C;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [7:0]            data_in = 8'h00;
    logic                  wr_valid = 1'b0;
    logic                  wr_ready;
    logic [DEPTH_LOG2:0]   tx_free;
    logic                  tx;
    logic                  busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_HZ        (CLK_HZ),
        .BAUD          (BAUD),
        .TX_FIFO_DEPTH (DEPTH_LOG2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_data_in  (data_in),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .o_tx_free  (tx_free),
        .o_tx       (tx),
        .o_busy     (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queued bytes plus the position inside the current frame (-1 = line idle).
    logic [7:0] q[$];
    int         pos = -1;
    logic [7:0] cur = 8'h00;
    bit         last_push = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos       = -1;
        last_push = 1'b0;
    endtask

    task automatic model_edge();
        bit push_ok;
        push_ok = wr_valid && (q.size() < DEPTH);
        if (pos < 0 && q.size() > 0) begin
            cur = q.pop_front();
            pos = 0;
            $display("pop  %02h", cur);
        end else if (pos >= 0) begin
            pos++;
            if (pos == F) pos = -1;
        end
        if (push_ok) begin
            q.push_back(data_in);
            $display("push %02h queued=%0d", data_in, q.size());
        end
        last_push = push_ok;
    endtask

    function automatic logic exp_tx();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        if (PAR_EN && b == 9) return ^cur;
        return 1'b1;
    endfunction

    task automatic compare_outputs();
        check_eq("tx",    32'(tx),       32'(exp_tx()));
        check_eq("busy",  32'(busy),     32'(pos >= 0));
        check_eq("ready", 32'(wr_ready), 32'(q.size() < DEPTH));
        check_eq("free",  32'(tx_free),  32'(DEPTH - q.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        data_in  = b;
        wr_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            done = last_push;
        end
        wr_valid = 1'b0;
        check_eq("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic busy_length(input string tag);
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < F + 20; i++) begin
            tick();
            busy_cycles += int'(busy);
        end
        check_eq(tag, busy_cycles, F);
    endtask

    initial begin
        int  gap;
        bit  prev_busy;
        bit  counting;
        bit  gap_done;

        // Reset state
        rst_n = 1'b0;
        idle(3);
        check_eq("rst_tx",    32'(tx),       32'd1);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_free",  32'(tx_free),  32'(DEPTH));
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Single byte and frame length
        send(8'hA5);
        busy_length("a5_busy_len");
        idle(4);

        // Fill the FIFO, then a sixth offer that must wait for a pop
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        check_eq("fill_free",  32'(tx_free),  32'd0);
        check_eq("fill_ready", 32'(wr_ready), 32'd0);
        send(8'h6E);
        idle(6 * F);

        // Back-to-back frames: exactly one idle clock between them
        send(8'h00);
        send(8'hFF);
        gap = 0; prev_busy = busy; counting = 1'b0; gap_done = 1'b0;
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            if (!gap_done) begin
                if (prev_busy && !busy) counting = 1'b1;
                if (counting && !busy) gap++;
                if (counting && busy) begin
                    counting = 1'b0;
                    gap_done = 1'b1;
                end
            end
            prev_busy = busy;
        end
        check_eq("b2b_gap", 32'(gap), 32'd1);
        idle(4);

        // Reset during data bit 3 of 0x0F with two bytes still queued
        send(8'h0F);
        send(8'h11);
        send(8'h22);
        for (int i = 0; i < 100 && pos != 4 * C + 1; i++) tick();
        check_eq("reach_bit3", 32'(pos), 32'(4 * C + 1));
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("abort_tx",    32'(tx),       32'd1);
        check_eq("abort_busy",  32'(busy),     32'd0);
        check_eq("abort_free",  32'(tx_free),  32'(DEPTH));
        check_eq("abort_ready", 32'(wr_ready), 32'd1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3 * F);

        // Parity-sensitive bytes (odd and even population)
        send(8'h07);
        busy_length("p07_busy_len");
        send(8'h03);
        idle(F + 4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            data_in  = 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        idle((DEPTH + 2) * (F + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
